// File: rtl/shared_slot_arbiter.sv
// Purpose: round-robin grant of a shared slot pool with a per-requester quota and release tracking.
// Latency: the grant is combinational in the same cycle; counts update on the next clk_i edge.
// Backpressure: a requester is not granted while it is at quota or the pool is full; a released slot can be granted from the next cycle.
module shared_slot_arbiter #(
   parameter int NumReq    = 4,
   parameter int Depth     = 8,
   parameter int MaxPerReq = 4,
   localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int CntW = $clog2(Depth + 1),
   localparam int RcW  = $clog2(MaxPerReq + 1)
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic [NumReq-1:0]     req_valid_i,
   output logic [NumReq-1:0]     req_ready_o,
   output logic [IdW-1:0]        grant_id_o,
   input  logic                  rel_valid_i,
   input  logic [IdW-1:0]        rel_id_i,
   output logic [CntW-1:0]       cnt_o,
   output logic [NumReq*RcW-1:0] req_cnt_o,
   output logic                  rel_err_o
);

   localparam logic [RcW-1:0]  MaxCnt   = RcW'(MaxPerReq);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   localparam logic [IdW-1:0]  LastId   = IdW'(NumReq - 1);

   logic [RcW-1:0]    req_cnt_q [NumReq];
   logic [RcW-1:0]    req_cnt_d [NumReq];
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
   logic              rel_err_q, rel_err_d;
   logic [NumReq-1:0] elig;
   logic              gnt_vld;
   logic [IdW-1:0]    gnt_idx;
   logic              rel_held;
   logic              rel_legal;
   int                idx;

   // Eligibility uses registered counts only, so a same-cycle release never opens a grant path.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NumReq; i++) begin
         elig[i] = req_valid_i[i] && (req_cnt_q[i] != MaxCnt) && (cnt_q != DepthCnt);
      end
   end

   // Round-robin search starting at rr_ptr_q; first eligible requester wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NumReq; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NumReq) begin
            idx = idx - NumReq;
         end
         if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IdW'(idx);
         end
      end
   end

   // Release is legal only for an in-range id that currently holds a slot; out-of-range ids match nothing.
   always_comb begin
      rel_held = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         if (rel_id_i == IdW'(i)) begin
            rel_held = (req_cnt_q[i] != '0);
         end
      end
      rel_legal = rel_valid_i && rel_held;
   end

   // Outputs: grant is forced low while reset is held so nothing handshakes during reset.
   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         req_ready_o[i] = arst_ni && gnt_vld && (gnt_idx == IdW'(i));
      end
      grant_id_o = (arst_ni && gnt_vld) ? gnt_idx : '0;
      cnt_o      = cnt_q;
      rel_err_o  = rel_err_q;
      for (int i = 0; i < NumReq; i++) begin
         req_cnt_o[i*RcW +: RcW] = req_cnt_q[i];
      end
   end

   // Next state: a grant and a release on the same id cancel; the pool total nets out likewise.
   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         req_cnt_d[i] = req_cnt_q[i];
         if (gnt_vld && (gnt_idx == IdW'(i)) && !(rel_legal && (rel_id_i == IdW'(i)))) begin
            req_cnt_d[i] = req_cnt_q[i] + 1'b1;
         end else if (rel_legal && (rel_id_i == IdW'(i)) && !(gnt_vld && (gnt_idx == IdW'(i)))) begin
            req_cnt_d[i] = req_cnt_q[i] - 1'b1;
         end
      end
      cnt_d = cnt_q;
      if (gnt_vld && !rel_legal) begin
         cnt_d = cnt_q + 1'b1;
      end else if (rel_legal && !gnt_vld) begin
         cnt_d = cnt_q - 1'b1;
      end
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = (gnt_idx == LastId) ? '0 : gnt_idx + 1'b1;
      end
      rel_err_d = rel_valid_i && !rel_legal;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int i = 0; i < NumReq; i++) begin
            req_cnt_q[i] <= '0;
         end
         cnt_q     <= '0;
         rr_ptr_q  <= '0;
         rel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            req_cnt_q[i] <= req_cnt_d[i];
         end
         cnt_q     <= cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         rel_err_q <= rel_err_d;
      end
   end

endmodule

// File: tb/tb_shared_slot_arbiter.sv
// Purpose: directed self-checking bench for shared_slot_arbiter at NumReq=4, Depth=8, MaxPerReq=4.
// Latency: inputs change 1ns after a rising edge, combinational outputs are sampled 1ns later.
// Backpressure: quota, pool-full and release/grant interactions are driven with hand-computed expectations.
module tb_shared_slot_arbiter;

   logic       clk_i = 1'b0;
   logic       arst_ni;
   logic [3:0] req_valid_i;
   logic [3:0] req_ready_o;
   logic [1:0] grant_id_o;
   logic       rel_valid_i;
   logic [1:0] rel_id_i;
   logic [3:0] cnt_o;
   logic [11:0] req_cnt_o;
   logic       rel_err_o;

   int checks   = 0;
   int failures = 0;

   shared_slot_arbiter #(.NumReq(4), .Depth(8), .MaxPerReq(4)) dut (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .grant_id_o  (grant_id_o),
      .rel_valid_i (rel_valid_i),
      .rel_id_i    (rel_id_i),
      .cnt_o       (cnt_o),
      .req_cnt_o   (req_cnt_o),
      .rel_err_o   (rel_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int rc(input int i);
      return int'(req_cnt_o[i*3 +: 3]);
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_counts(input string tag, input int c, input int c0, input int c1, input int c2, input int c3);
      chk({tag, "_cnt"}, int'(cnt_o), c);
      chk({tag, "_rc0"}, rc(0), c0);
      chk({tag, "_rc1"}, rc(1), c1);
      chk({tag, "_rc2"}, rc(2), c2);
      chk({tag, "_rc3"}, rc(3), c3);
   endtask

   initial begin
      arst_ni     = 1'b0;
      req_valid_i = 4'hF;
      rel_valid_i = 1'b0;
      rel_id_i    = 2'd0;
      #2;
      // reset state: requests present but nothing granted
      chk("rst_ready", int'(req_ready_o), 0);
      chk("rst_gid", int'(grant_id_o), 0);
      chk("rst_err", int'(rel_err_o), 0);
      chk_counts("rst", 0, 0, 0, 0, 0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      arst_ni = 1'b1;

      // all four requesting for 8 cycles: strict rotation 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++) begin
         req_valid_i = 4'hF;
         #1;
         chk($sformatf("rr_gid%0d", k), int'(grant_id_o), k % 4);
         chk($sformatf("rr_rdy%0d", k), int'(req_ready_o), 1 << (k % 4));
         tick();
      end
      chk_counts("rr", 8, 2, 2, 2, 2);
      chk("full_rdy", int'(req_ready_o), 0);

      // full pool: release of 1 with request from 1 in the same cycle -> no grant yet
      req_valid_i = 4'b0010;
      rel_valid_i = 1'b1;
      rel_id_i    = 2'd1;
      #1;
      chk("fullrel_rdy", int'(req_ready_o), 0);
      tick();
      chk_counts("fullrel", 7, 2, 1, 2, 2);
      rel_valid_i = 1'b0;
      #1;
      chk("freed_rdy", int'(req_ready_o), 4'b0010);
      chk("freed_gid", int'(grant_id_o), 1);
      tick();
      chk_counts("freed", 8, 2, 2, 2, 2);
      req_valid_i = 4'b0000;

      // drain requester 3 with two legal releases
      rel_valid_i = 1'b1;
      rel_id_i    = 2'd3;
      tick();
      chk("legal_err", int'(rel_err_o), 0);
      tick();
      chk_counts("drain3", 6, 2, 2, 2, 0);

      // illegal release of an empty requester: counts hold, one-cycle error pulse
      tick();
      chk_counts("illegal", 6, 2, 2, 2, 0);
      chk("illegal_err", int'(rel_err_o), 1);
      rel_valid_i = 1'b0;
      tick();
      chk("err_clear", int'(rel_err_o), 0);

      // bring total to 5
      rel_valid_i = 1'b1;
      rel_id_i    = 2'd1;
      tick();
      chk_counts("to5", 5, 2, 1, 2, 0);

      // grant to 0 and release of 0 together: everything nets out
      req_valid_i = 4'b0001;
      rel_id_i    = 2'd0;
      #1;
      chk("net_same_rdy", int'(req_ready_o), 4'b0001);
      tick();
      chk_counts("net_same", 5, 2, 1, 2, 0);

      // grant to 0 and release of 2 together
      rel_id_i = 2'd2;
      #1;
      chk("net_diff_gid", int'(grant_id_o), 0);
      tick();
      chk_counts("net_diff", 5, 3, 1, 1, 0);
      rel_valid_i = 1'b0;

      // burst: rr pointer is at 1 so requester 1 wins
      req_valid_i = 4'hF;
      #1;
      chk("burst_gid", int'(grant_id_o), 1);
      tick();
      chk_counts("burst", 6, 3, 2, 1, 0);

      // asynchronous reset mid-cycle with requests still asserted
      #2;
      arst_ni = 1'b0;
      #1;
      chk("arst_ready", int'(req_ready_o), 0);
      chk("arst_gid", int'(grant_id_o), 0);
      chk_counts("arst", 0, 0, 0, 0, 0);
      #1;
      arst_ni = 1'b1;
      #1;
      chk("post_rst_gid", int'(grant_id_o), 0);
      chk("post_rst_rdy", int'(req_ready_o), 4'b0001);
      tick();
      chk_counts("post_rst", 1, 1, 0, 0, 0);

      // only requester 2: four grants then quota stops it although pool has room
      req_valid_i = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("quota_rdy%0d", k), int'(req_ready_o), 4'b0100);
         tick();
      end
      #1;
      chk("quota_stop_rdy", int'(req_ready_o), 0);
      chk_counts("quota", 5, 1, 0, 4, 0);
      req_valid_i = 4'b0000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shared_slot_arbiter.md
SHARED_SLOT_ARBITER -- requirements
Module: shared_slot_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter Depth, default 8: total shared slots (>=1).
REQ-003 SHALL have parameter MaxPerReq, default 4: per-requester slot quota (1..Depth).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port arst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NumReq  per-requester slot request.
REQ-007 SHALL have port req_ready_o  output  NumReq  one-hot-or-zero grant; handshake = valid & ready.
REQ-008 SHALL have port grant_id_o  output  $clog2(NumReq)  index of granted requester; 0 when no grant.
REQ-009 SHALL have port rel_valid_i  input  1  slot release strobe.
REQ-010 SHALL have port rel_id_i  input  $clog2(NumReq)  requester whose slot is released.
REQ-011 SHALL have port cnt_o  output  $clog2(Depth+1)  total slots held.
REQ-012 SHALL have port req_cnt_o  output  NumReq*$clog2(MaxPerReq+1)  per-requester held counts, requester i at slice i.
REQ-013 SHALL have port rel_err_o  output  1  one-cycle pulse on illegal release.

Function
REQ-014 SHALL mark requester i eligible when req_valid_i[i] & req_cnt[i] != MaxPerReq & cnt_o != Depth.
REQ-015 SHALL grant at most one eligible requester per cycle, combinationally, selected round-robin starting at pointer rr_ptr.
REQ-016 SHALL assert req_ready_o[i] only for the granted requester; all zero when none eligible.
REQ-017 SHALL update rr_ptr to (granted index + 1) mod NumReq on a grant; hold otherwise.
REQ-018 SHALL on grant increment req_cnt[granted] and cnt_o by 1 at next edge.
REQ-019 SHALL treat a release as legal when rel_valid_i & req_cnt[rel_id_i] != 0; legal release decrements req_cnt[rel_id_i] and cnt_o by 1.
REQ-020 SHALL ignore an illegal release (zero count or rel_id_i >= NumReq), leave counts unchanged, and pulse rel_err_o next cycle.
REQ-021 SHALL net simultaneous grant and legal release: same id -> that req_cnt unchanged; cnt_o unchanged in both cases.
REQ-022 SHALL NOT use the current-cycle release to make a requester eligible (no rel_valid_i -> req_ready_o combinational path); freed slot grantable next cycle.
REQ-023 SHALL never let cnt_o exceed Depth nor any req_cnt exceed MaxPerReq; no wrap-around.
REQ-024 SHALL keep cnt_o equal to the sum of all req_cnt at every edge.
REQ-025 SHALL not depend on req_valid_i being held; a dropped request is simply not granted.

Reset
REQ-026 SHALL on arst_ni low immediately clear cnt_o, all req_cnt, rr_ptr, rel_err_o to 0, independent of clk_i.
REQ-027 SHALL drive req_ready_o 0 and grant_id_o 0 while arst_ni low.
REQ-028 SHALL discard in-flight handshakes when reset asserts mid-operation; first grant after release of reset starts at requester 0.

Verification
REQ-029 SHALL be covered: all four req_valid_i high for 8 cycles, Depth=8, MaxPerReq=4 -> grants 0,1,2,3,0,1,2,3; cnt_o=8; each req_cnt=2; then all ready low.
REQ-030 SHALL be covered: only requester 2 requesting, MaxPerReq=4 -> 4 grants in 4 cycles, req_cnt[2]=4, req_ready_o[2] low on 5th cycle though cnt_o=4<Depth.
REQ-031 SHALL be covered: cnt_o=8 (full), rel_valid_i with rel_id_i=1 and req_valid_i[1] high same cycle -> no grant that cycle, cnt_o=7, grant to 1 next cycle, cnt_o=8.
REQ-032 SHALL be covered: req_cnt[3]=0, rel_valid_i with rel_id_i=3 -> counts unchanged, rel_err_o=1 for exactly one cycle.
REQ-033 SHALL be covered: cnt_o=5, grant to 0 and legal release of id 0 same cycle -> cnt_o=5, req_cnt[0] unchanged; release of id 2 instead -> req_cnt[0]+1, req_cnt[2]-1.
REQ-034 SHALL be covered: arst_ni low asynchronously mid-burst with cnt_o=6 -> cnt_o=0, req_ready_o=0 before next clk_i edge; after deassert first grant is requester 0.
